fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side drain stage placed directly downstream of the asynchronous FIFO's read port, in the read clock domain. It issues FIFO read enables, absorbs the FIFO's one-cycle read latency in a 3-entry buffer, and presents the words as a valid/ready stream. The stream is framed into fixed-length packets with a last-beat marker and a completed-packet counter.

## Interface
- WIDTH, 32, data word width; must match the FIFO's WIDTH.
- PKT_LEN, 16, words per packet; legal range 2..65535.

- CLK  in  1  read-domain clock, the same clock as the FIFO's CLK_r.
- RST  in  1  reset; asynchronous, active-high.
- fifo_empty  in  1  FIFO Empty flag.
- fifo_data  in  WIDTH  FIFO data_out.
- fifo_en  out  1  FIFO read enable (EN_r).
- m_data  out  WIDTH  stream data.
- m_valid  out  1  stream word valid.
- m_last  out  1  high on the final word of each packet.
- m_ready  in  1  downstream accept.
- pkt_count  out  16  count of completed packets, wraps modulo 2^16.

## Operation
- **FIFO read contract.** A read occurs at a CLK edge where fifo_en=1 and fifo_empty=0. The word is valid on fifo_data after that edge and is captured at the next edge.
- **Registered state.**
  - buffer: 3-entry circular, with rd_ptr and wr_ptr (2 bits, wrap 2→0).
  - occ: 0..3, number of words held in the buffer.
  - inflight: 1 bit, set on the cycle after a read is issued.
  - beat: 16-bit packet beat counter.
  - pkt_count.
- **fifo_en** = !RST && !fifo_empty && (occ + inflight < 3).
  - Depends only on registered state and fifo_empty; it has no combinational path from m_ready.
- **Capture.** When inflight=1, fifo_data is written at wr_ptr and wr_ptr advances.
- **Output.**
  - m_valid = (occ != 0).
  - m_data = buffer[rd_ptr].
  - m_last = m_valid && (beat == PKT_LEN-1).
- **Handshake** is m_valid && m_ready.
  - rd_ptr advances.
  - beat increments. If beat was PKT_LEN-1, beat returns to 0 and pkt_count increments.
- **Simultaneous capture and handshake in one cycle:** occ is unchanged; both pointers advance.
- **occ update:** occ_next = occ + inflight - handshake. It never exceeds 3 (guaranteed by the fifo_en rule) and never goes below 0.
- **Backpressure.** While m_valid=1 and m_ready=0, m_data and m_last hold stable. m_valid never deasserts without a handshake.
- **Partial packets.** There is no timeout and no flush. A packet completes only when its PKT_LEN-th word is accepted.
- **Reset.**
  - Asserting RST clears occ, inflight, pointers, beat and pkt_count immediately.
  - Outputs go to m_valid=0, m_last=0, fifo_en=0, pkt_count=0; m_data reads the cleared entry, value 0.
  - A read in flight when RST asserts is discarded; that word is lost. The FIFO is reset together with this block at system level.

## Timing
- **Latency.** FIFO non-empty to first m_valid is 2 cycles:
  - edge 0: fifo_en sampled high;
  - edge 1: capture, occ=1;
  - m_valid is high after edge 1.
- **Throughput.** 1 word/cycle sustained while the FIFO is non-empty and m_ready=1. Steady state is occ=1, inflight=1, with fifo_en high every cycle.
- **Backpressure.** With m_ready=0, fifo_en drops once occ+inflight reaches 3, and at most 3 words are buffered. When m_ready returns, the first accept frees a slot and fifo_en may rise the following cycle, after occ drops.
- **Empty boundary.** fifo_en=0 whenever fifo_empty=1, so no read is ever issued on an empty FIFO. m_valid falls in the cycle after the last buffered word is accepted.
- **Counters.** beat and pkt_count update on the edge that completes the handshake. pkt_count wraps from 65535 to 0.

## Test plan
- **Reset values.** Assert RST mid-cycle with no clock edge → m_valid=0, m_last=0, fifo_en=0, pkt_count=0, all immediately.
- **Streaming.** Preload the FIFO with 32 random words, m_ready=1 → 32 words out in order on 32 consecutive cycles, starting 2 cycles after the first fifo_en. m_last is high on words 16 and 32; pkt_count ends at 2.
- **Backpressure.** Hold m_ready=0 with the FIFO holding 10 words → exactly 3 reads issued, then fifo_en=0; m_data stays stable. Release m_ready → all 10 words delivered in order, with no duplicates and none lost.
- **Random ready and bursty FIFO.** Random m_ready (50%), with fifo_empty toggling as a FIFO written in bursts → the output sequence equals the write sequence; no fifo_en ever occurs while fifo_empty=1.
- **Partial packet.** PKT_LEN=16, 20 words written → m_last only on word 16, pkt_count=1, beat=4 at the end. Writing 12 more words → m_last on word 32, pkt_count=2.
- **Reset mid-stream.** Assert RST with occ=2 and inflight=1 → buffer emptied and no stale word appears after release. Release RST, write 3 new words → exactly those 3 words are output, and beat restarts at 0.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Groups the FIFO read-port signals and the outgoing packet stream of the drain stage.
// Latency: none; this is wiring only.
// Backpressure: m_ready from the stream consumer; the FIFO side is throttled through fifo_en.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 32
);
    // FIFO read port
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_en;
    // outgoing stream
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    // status
    logic [15:0]      pkt_count;

    // The drain stage: reads the FIFO and sources the stream.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_en,
        output m_data,
        output m_valid,
        output m_last,
        output pkt_count
    );

    // The surroundings: FIFO read port plus stream sink.
    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_en,
        input  m_data,
        input  m_valid,
        input  m_last,
        input  pkt_count
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a framed valid/ready stream with a packet counter.
// Latency: 2 cycles from fifo_en sampled high to m_valid; 1 word/cycle sustained.
// Backpressure: up to 3 words buffered; fifo_en drops once buffered + in-flight words reach 3.
module fifo_rd_stream #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 16
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_rd_stream_if.master  bus
);

    // Buffer storage and bookkeeping.  The buffer has three slots because a
    // read issued while two words are already held still needs somewhere to
    // land one cycle later, and fifo_en must not look at m_ready.
    logic [WIDTH-1:0] mem_q [3];
    logic [WIDTH-1:0] mem_d [3];
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [15:0]      beat_q, beat_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic             hs;
    logic             beat_last;
    logic [2:0]       committed;

    // Pointers walk 0,1,2,0,...
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words held plus the word still travelling out of the FIFO; a new read is
    // only allowed while this leaves a free slot for its capture.
    assign committed  = {1'b0, occ_q} + {2'b00, inflight_q};

    assign bus.fifo_en   = !RST && !bus.fifo_empty && (committed < 3'd3);
    assign bus.m_valid   = (occ_q != 2'd0);
    assign bus.m_data    = mem_q[rd_ptr_q];
    assign beat_last     = (beat_q == 16'(PKT_LEN - 1));
    assign bus.m_last    = bus.m_valid && beat_last;
    assign bus.pkt_count = pkt_count_q;

    assign hs         = bus.m_valid && bus.m_ready;
    assign inflight_d = bus.fifo_en;

    // Next-state: capture the returning FIFO word, retire accepted words, frame packets.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_d      = beat_q;
        pkt_count_d = pkt_count_q;

        if (inflight_q) begin
            mem_d[wr_ptr_q] = bus.fifo_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        if (hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (beat_last) begin
                beat_d      = 16'd0;
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                beat_d = beat_q + 16'd1;
            end
        end

        // Capture and accept in the same cycle cancel out; the fifo_en
        // throttle keeps this within 0..3.
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, hs};
    end

    // State registers; reset drops any word still in flight from the FIFO.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            beat_q      <= 16'd0;
            pkt_count_q <= 16'd0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule
